// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, 4-state countdown FSM, IRQ to CP0.
// Optional tick prescaler enabled by defining TIMER_PRESCALE_EN.
module timer_dev #(
    parameter logic [31:0] BASE_ADDR     = 32'h0000_7f00,
    parameter int          PRESCALE_LOG2 = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] iAddr,
    input  logic [31:0] iData,
    input  logic [3:0]  iBE,
    output logic [31:0] oData,
    output logic        oIRQ
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;
    logic        irq_q, irq_d;
    logic        hit, we, wr_ctrl, wr_preset, en_now, tick;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^iAddr[1:0];

`ifdef TIMER_PRESCALE_EN
    logic [PRESCALE_LOG2-1:0] div_q, div_d;

    assign tick  = &div_q;
    assign div_d = (state_q == S_LOAD) ? '0 : div_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) div_q <= '0;
        else       div_q <= div_d;
    end
`else
    assign tick = 1'b1;
`endif

    assign hit       = (iAddr[31:4] == BASE_ADDR[31:4]);
    assign we        = (iBE == 4'b1111) && hit;
    assign wr_ctrl   = we && (iAddr[3:2] == 2'b00);
    assign wr_preset = we && (iAddr[3:2] == 2'b01);
    // A same-cycle Enable=0 write stops counting immediately rather than one edge late.
    assign en_now    = wr_ctrl ? iData[0] : ctrl_q[0];

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        if (wr_ctrl)   ctrl_d   = iData[3:0];
        if (wr_preset) preset_d = iData;
        if (wr_ctrl || wr_preset) irq_flag_d = 1'b0;

        case (state_q)
            S_IDLE: if (ctrl_q[0]) state_d = S_LOAD;
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!en_now) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    if (count_q > 32'd1) begin
                        count_d = count_q - 32'd1;
                    end else begin
                        count_d    = 32'd0;
                        irq_flag_d = 1'b1;
                        state_d    = S_INT;
                    end
                end
            end
            S_INT: begin
                if (ctrl_q[2:1] == 2'b01) begin
                    state_d    = S_LOAD;
                    irq_flag_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                    // Software writing CTRL this cycle wins over the one-shot Enable clear.
                    if (!wr_ctrl) ctrl_d[0] = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        irq_d = irq_flag_d & ctrl_d[3];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ctrl_q     <= 4'd0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            irq_flag_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        case (iAddr[3:2])
            2'b00:   oData = {28'd0, ctrl_q};
            2'b01:   oData = preset_q;
            2'b10:   oData = count_q;
            default: oData = 32'd0;
        endcase
    end

    assign oIRQ = irq_q;
endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: two instances (0x7f00, 0x7f10) on a shared store bus.
module tb_timer_dev;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] iAddr, iData;
    logic [3:0]  iBE;
    logic [31:0] o0, o1;
    logic        irq0, irq1;
    int          total = 0;
    int          bad   = 0;

    timer_dev #(.BASE_ADDR(32'h0000_7f00), .PRESCALE_LOG2(4)) u_t0 (
        .clk(clk), .reset(reset), .iAddr(iAddr), .iData(iData), .iBE(iBE), .oData(o0), .oIRQ(irq0));
    timer_dev #(.BASE_ADDR(32'h0000_7f10), .PRESCALE_LOG2(4)) u_t1 (
        .clk(clk), .reset(reset), .iAddr(iAddr), .iData(iData), .iBE(iBE), .oData(o1), .oIRQ(irq1));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        iAddr = a; iData = d; iBE = be;
        tick();
        iBE = 4'b0000;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d0, output logic [31:0] d1);
        iAddr = a;
        #1;
        d0 = o0;
        d1 = o1;
    endtask

    task automatic do_reset();
        iBE = 4'b0000; iAddr = 32'd0; iData = 32'd0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d0, d1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rd(32'h7f00 + 32'(i * 4), d0, d1);
            total++;
            if (d0 !== 32'd0) begin bad++; $display("FAIL reset_read off=%0d got=%h exp=0", i * 4, d0); end
        end
        total++;
        if (irq0 !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq0); end
        wr(32'h7f08, 32'h1234, 4'b1111);
        rd(32'h7f08, d0, d1);
        total++;
        if (d0 !== 32'd0) begin bad++; $display("FAIL count_readonly got=%h exp=0", d0); end
    endtask

    task automatic test_mode0();
        logic [31:0] d0, d1;
        logic [31:0] exp_cnt [1:5] = '{32'd0, 32'd3, 32'd2, 32'd1, 32'd0};
        do_reset();
        wr(32'h7f04, 32'd3, 4'b1111);
        wr(32'h7f00, 32'h9, 4'b1111);
        for (int k = 1; k <= 5; k++) begin
            tick();
            rd(32'h7f08, d0, d1);
            total++;
            if (d0 !== exp_cnt[k]) begin bad++; $display("FAIL m0_count E%0d got=%0d exp=%0d", k, d0, exp_cnt[k]); end
            total++;
            if (irq0 !== (k == 5)) begin bad++; $display("FAIL m0_irq E%0d got=%b exp=%b", k, irq0, (k == 5)); end
        end
        tick();
        rd(32'h7f00, d0, d1);
        total++;
        if (d0 !== 32'h8) begin bad++; $display("FAIL m0_ctrl_cleared got=%h exp=8", d0); end
        tick(); tick();
        total++;
        if (irq0 !== 1'b1) begin bad++; $display("FAIL m0_irq_held got=%b exp=1", irq0); end
        wr(32'h7f04, 32'd7, 4'b1111);
        total++;
        if (irq0 !== 1'b0) begin bad++; $display("FAIL m0_irq_clear got=%b exp=0", irq0); end
    endtask

    task automatic test_mode1();
        logic [31:0] d0, d1;
        logic [31:0] exp_c;
        do_reset();
        wr(32'h7f04, 32'd2, 4'b1111);
        wr(32'h7f00, 32'hB, 4'b1111);
        for (int k = 1; k <= 13; k++) begin
            tick();
            rd(32'h7f08, d0, d1);
            exp_c = (k % 4 == 2) ? 32'd2 : (k % 4 == 3) ? 32'd1 : 32'd0;
            total++;
            if (d0 !== exp_c) begin bad++; $display("FAIL m1_count E%0d got=%0d exp=%0d", k, d0, exp_c); end
            total++;
            if (irq0 !== (k % 4 == 0)) begin bad++; $display("FAIL m1_irq E%0d got=%b exp=%b", k, irq0, (k % 4 == 0)); end
        end
    endtask

    task automatic test_small_preset();
        logic [31:0] d0, d1;
        for (int p = 0; p <= 1; p++) begin
            do_reset();
            wr(32'h7f04, 32'(p), 4'b1111);
            wr(32'h7f00, 32'h9, 4'b1111);
            tick(); tick();
            total++;
            if (irq0 !== 1'b0) begin bad++; $display("FAIL small_preset_E2 p=%0d got=%b exp=0", p, irq0); end
            tick();
            total++;
            if (irq0 !== 1'b1) begin bad++; $display("FAIL small_preset_E3 p=%0d got=%b exp=1", p, irq0); end
            rd(32'h7f08, d0, d1);
            total++;
            if (d0 !== 32'd0) begin bad++; $display("FAIL small_preset_cnt p=%0d got=%0d exp=0", p, d0); end
        end
    endtask

    task automatic test_disable();
        logic [31:0] d0, d1, frozen;
        do_reset();
        wr(32'h7f04, 32'd10, 4'b1111);
        wr(32'h7f00, 32'h9, 4'b1111);
        for (int k = 0; k < 5; k++) tick();
        wr(32'h7f00, 32'h0, 4'b0011);
        rd(32'h7f08, d0, d1);
        total++;
        if (d0 !== 32'd6) begin bad++; $display("FAIL dis_partial_be_count got=%0d exp=6", d0); end
        rd(32'h7f00, d0, d1);
        total++;
        if (d0 !== 32'h9) begin bad++; $display("FAIL dis_partial_be_ctrl got=%h exp=9", d0); end
        wr(32'h7f00, 32'h0, 4'b1111);
        rd(32'h7f08, frozen, d1);
        total++;
        if (frozen !== 32'd6 && frozen !== 32'd5) begin bad++; $display("FAIL dis_freeze got=%0d exp=5or6", frozen); end
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if (irq0 !== 1'b0) begin bad++; $display("FAIL dis_irq step=%0d got=%b exp=0", k, irq0); end
        end
        rd(32'h7f08, d0, d1);
        total++;
        if (d0 !== frozen) begin bad++; $display("FAIL dis_hold got=%0d exp=%0d", d0, frozen); end
    endtask

    task automatic test_preset_during_cnt();
        logic [31:0] d0, d1;
        do_reset();
        wr(32'h7f04, 32'd4, 4'b1111);
        wr(32'h7f00, 32'h3, 4'b1111);
        tick(); tick();
        wr(32'h7f04, 32'd2, 4'b1111);
        rd(32'h7f08, d0, d1);
        total++;
        if (d0 !== 32'd3) begin bad++; $display("FAIL pcnt_undisturbed got=%0d exp=3", d0); end
        for (int k = 0; k < 5; k++) tick();
        rd(32'h7f08, d0, d1);
        total++;
        if (d0 !== 32'd2) begin bad++; $display("FAIL pcnt_reload got=%0d exp=2", d0); end
    endtask

    task automatic test_addr_decode();
        logic [31:0] d0, d1;
        do_reset();
        wr(32'h7f04, 32'h55, 4'b1111);
        rd(32'h7f04, d0, d1);
        total++;
        if (d0 !== 32'h55) begin bad++; $display("FAIL dec_t0_hit got=%h exp=55", d0); end
        total++;
        if (d1 !== 32'h0) begin bad++; $display("FAIL dec_t1_miss got=%h exp=0", d1); end
        wr(32'h7f14, 32'h66, 4'b1111);
        wr(32'h8004, 32'h77, 4'b1111);
        rd(32'h7f14, d0, d1);
        total++;
        if (d1 !== 32'h66) begin bad++; $display("FAIL dec_t1_hit got=%h exp=66", d1); end
        total++;
        if (d0 !== 32'h55) begin bad++; $display("FAIL dec_t0_keep got=%h exp=55", d0); end
    endtask

    task automatic test_reset_midcnt();
        logic [31:0] d0, d1;
        do_reset();
        wr(32'h7f04, 32'd10, 4'b1111);
        wr(32'h7f00, 32'h9, 4'b1111);
        for (int k = 0; k < 4; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd(32'h7f00 + 32'(i * 4), d0, d1);
            total++;
            if (d0 !== 32'd0) begin bad++; $display("FAIL midrst_reg off=%0d got=%h exp=0", i * 4, d0); end
        end
        tick(); tick(); tick();
        rd(32'h7f08, d0, d1);
        total++;
        if (d0 !== 32'd0 || irq0 !== 1'b0) begin bad++; $display("FAIL midrst_idle cnt=%0d irq=%b exp=0/0", d0, irq0); end
    endtask

    initial begin
        reset = 1'b1; iAddr = 32'd0; iData = 32'd0; iBE = 4'b0000;
        test_reset();
        test_mode0();
        test_mode1();
        test_small_preset();
        test_disable();
        test_preset_during_cnt();
        test_addr_decode();
        test_reset_midcnt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
